adder_32: RTL and testbench



---
 rtl/adder_32_pkg.sv | 33 +++
 rtl/adder_32_cla_4.sv | 34 +++
 rtl/adder_32.sv | 55 +++++
 tb/tb_adder_32.sv | 134 +++++++++++++
 4 files changed

// File: rtl/adder_32_pkg.sv
// Shared width constants and the group-level carry lookahead helper for adder_32.
package adder_32_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned GROUP_W = 4;
   localparam int unsigned GROUPS  = DATA_W / GROUP_W;

   // Carry into group k (k = 0..GROUPS), expanded as a flat sum of products
   // over group generate/propagate terms rather than a chain.
   function automatic logic group_carry(
      input logic [GROUPS-1:0] g,
      input logic [GROUPS-1:0] p,
      input logic              c_in,
      input int unsigned       k
   );
      logic acc;
      logic prop;
      acc  = 1'b0;
      for (int unsigned j = 0; j < k; j++) begin
         prop = 1'b1;
         for (int unsigned m = j + 1; m < k; m++) begin
            prop = prop & p[m];
         end
         acc = acc | (g[j] & prop);
      end
      prop = 1'b1;
      for (int unsigned m = 0; m < k; m++) begin
         prop = prop & p[m];
      end
      return acc | (prop & c_in);
   endfunction

endpackage

// File: rtl/adder_32_cla_4.sv
// 4-bit carry-lookahead slice producing sum bits and group generate/propagate.
module cla_4
   import adder_32_pkg::*;
(
   input  logic [GROUP_W-1:0] x,
   input  logic [GROUP_W-1:0] y,
   input  logic               c_in,
   output logic [GROUP_W-1:0] sum,
   output logic               g,
   output logic               p
);

   logic [GROUP_W-1:0] bit_g;
   logic [GROUP_W-1:0] bit_p;
   logic [GROUP_W-1:0] carry;

   assign bit_g = x & y;
   assign bit_p = x ^ y;

   // In-group lookahead carries; bit 0 takes the group carry-in directly.
   always_comb begin
      carry[0] = c_in;
      carry[1] = bit_g[0] | (bit_p[0] & c_in);
      carry[2] = bit_g[1] | (bit_p[1] & bit_g[0]) | (bit_p[1] & bit_p[0] & c_in);
      carry[3] = bit_g[2] | (bit_p[2] & bit_g[1]) | (bit_p[2] & bit_p[1] & bit_g[0])
               | (bit_p[2] & bit_p[1] & bit_p[0] & c_in);
   end

   assign sum = bit_p ^ carry;
   assign g   = bit_g[3] | (bit_p[3] & bit_g[2]) | (bit_p[3] & bit_p[2] & bit_g[1])
              | (bit_p[3] & bit_p[2] & bit_p[1] & bit_g[0]);
   assign p   = &bit_p;

endmodule

// File: rtl/adder_32.sv
// 32-bit two-level carry-lookahead adder with combinational and registered results.
module adder_32
   import adder_32_pkg::*;
(
   input  logic              clk,
   input  logic              in_reset,
   input  logic [DATA_W-1:0] in_x,
   input  logic [DATA_W-1:0] in_y,
   input  logic              in_carry,
   output logic [DATA_W-1:0] out_sum,
   output logic              out_carry,
   output logic              out_overflow,
   output logic [DATA_W-1:0] out_sum_r,
   output logic              out_carry_r,
   output logic              out_overflow_r
);

   logic [GROUPS-1:0] grp_g;
   logic [GROUPS-1:0] grp_p;
   logic [GROUPS:0]   grp_c;

   // Second-level lookahead: every group carry is a direct function of G, P and carry-in.
   for (genvar k = 0; k <= GROUPS; k++) begin : g_carry
      assign grp_c[k] = group_carry(grp_g, grp_p, in_carry, k);
   end

   for (genvar i = 0; i < GROUPS; i++) begin : g_grp
      cla_4 u_cla (
         .x    (in_x[i*GROUP_W +: GROUP_W]),
         .y    (in_y[i*GROUP_W +: GROUP_W]),
         .c_in (grp_c[i]),
         .sum  (out_sum[i*GROUP_W +: GROUP_W]),
         .g    (grp_g[i]),
         .p    (grp_p[i])
      );
   end

   // Carry into bit 31 is recovered from its sum bit: sum31 = p31 ^ c31.
   assign out_carry    = grp_c[GROUPS];
   assign out_overflow = (in_x[DATA_W-1] ^ in_y[DATA_W-1] ^ out_sum[DATA_W-1]) ^ out_carry;

   // Registered copy of result and flags; reset takes priority over new data.
   always_ff @(posedge clk) begin
      if (in_reset) begin
         out_sum_r      <= '0;
         out_carry_r    <= 1'b0;
         out_overflow_r <= 1'b0;
      end else begin
         out_sum_r      <= out_sum;
         out_carry_r    <= out_carry;
         out_overflow_r <= out_overflow;
      end
   end

endmodule

// File: tb/tb_adder_32.sv
// Self-checking bench for adder_32: directed table, reset sequences, random regression.
module tb_adder_32;

   logic        clk;
   logic        in_reset;
   logic [31:0] in_x;
   logic [31:0] in_y;
   logic        in_carry;
   logic [31:0] out_sum;
   logic        out_carry;
   logic        out_overflow;
   logic [31:0] out_sum_r;
   logic        out_carry_r;
   logic        out_overflow_r;

   int n_checks;
   int n_fail;

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic        c;
      logic [31:0] sum;
      logic        carry;
      logic        ovf;
   } vec_t;

   vec_t vecs[12];

   adder_32 dut (
      .clk            (clk),
      .in_reset       (in_reset),
      .in_x           (in_x),
      .in_y           (in_y),
      .in_carry       (in_carry),
      .out_sum        (out_sum),
      .out_carry      (out_carry),
      .out_overflow   (out_overflow),
      .out_sum_r      (out_sum_r),
      .out_carry_r    (out_carry_r),
      .out_overflow_r (out_overflow_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Drive a vector away from the edge, check combinational, then registered after the edge.
   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      in_x = v.x; in_y = v.y; in_carry = v.c;
      #1;
      check({tag, " sum"},   out_sum,             v.sum);
      check({tag, " carry"}, 32'(out_carry),      32'(v.carry));
      check({tag, " ovf"},   32'(out_overflow),   32'(v.ovf));
      @(posedge clk); #1;
      check({tag, " sum_r"},   out_sum_r,           v.sum);
      check({tag, " carry_r"}, 32'(out_carry_r),    32'(v.carry));
      check({tag, " ovf_r"},   32'(out_overflow_r), 32'(v.ovf));
   endtask

   initial begin
      vec_t        rv;
      logic [32:0] ref33;
      n_checks = 0;
      n_fail   = 0;

      vecs[0]  = '{32'hFFFF_FFFB, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0};
      vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[4]  = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
      vecs[5]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      vecs[6]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
      vecs[7]  = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
      vecs[8]  = '{32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0, 1'b0};
      vecs[9]  = '{32'h0FFF_FFFF, 32'h0000_0000, 1'b1, 32'h1000_0000, 1'b0, 1'b0};
      vecs[10] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vecs[11] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};

      // Reset held for two edges with non-zero inputs: reset must win.
      in_reset = 1'b1;
      in_x = 32'hFFFF_FFFF; in_y = 32'hFFFF_FFFF; in_carry = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset sum_r",   out_sum_r,           32'h0);
      check("reset carry_r", 32'(out_carry_r),    32'h0);
      check("reset ovf_r",   32'(out_overflow_r), 32'h0);
      check("reset comb sum", out_sum,            32'hFFFF_FFFF);

      // First edge after deassert captures 0x1E + 0x4.
      @(negedge clk);
      in_reset = 1'b0;
      in_x = 32'h1E; in_y = 32'h4; in_carry = 1'b0;
      @(posedge clk); #1;
      check("post-reset sum_r", out_sum_r, 32'h22);

      // Re-assert reset: registers clear, combinational path unaffected.
      @(negedge clk);
      in_reset = 1'b1;
      @(posedge clk); #1;
      check("re-reset sum_r",   out_sum_r,        32'h0);
      check("re-reset carry_r", 32'(out_carry_r), 32'h0);
      check("re-reset comb sum", out_sum,         32'h22);
      @(negedge clk);
      in_reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         apply(vecs[i], $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 10000; i++) begin
         rv.x  = $urandom;
         rv.y  = $urandom;
         rv.c  = 1'($urandom_range(1, 0));
         ref33 = {1'b0, rv.x} + {1'b0, rv.y} + 33'(rv.c);
         rv.sum   = ref33[31:0];
         rv.carry = ref33[32];
         rv.ovf   = (rv.x[31] == rv.y[31]) && (ref33[31] != rv.x[31]);
         apply(rv, $sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
